// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared FSM state type and default constants for the multi-channel clock divider.
package clk_div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, SYNC} state_t;
    localparam int CNT_W       = 9;
    localparam int DEFAULT_DIV = 127;
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divided-clock channel (half-period counter, toggle flop, tick strobe).
module clk_div_channel import clk_div_pkg::*; #(
    parameter int CNT_W       = clk_div_pkg::CNT_W,
    parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
    parameter int RST_PHASE   = 0,
    parameter bit INIT_LEVEL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             sync,
    input  logic [CNT_W-1:0] div_shadow,
    input  logic [CNT_W-1:0] phase_shadow,
    output logic             out_clk,
    output logic             tick
);
    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_div <= CNT_W'(DEFAULT_DIV);
            cnt        <= CNT_W'(RST_PHASE);
            out_clk    <= INIT_LEVEL;
            tick       <= 1'b0;
        end else if (sync) begin
            active_div <= div_shadow;
            cnt        <= (phase_shadow > div_shadow) ? div_shadow : phase_shadow;
            out_clk    <= INIT_LEVEL;
            tick       <= 1'b0;
        end else if (run) begin
            // >= rather than == so a counter can never run past its divide value
            if (cnt >= active_div) begin
                cnt     <= '0;
                out_clk <= ~out_clk;
                tick    <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH independent clock dividers sharing one load/resync FSM
// with shadowed divide and phase settings applied together in a single SYNC cycle.
module multi_clock_divider #(
    parameter int                NUM_CH      = 2,
    parameter int                CNT_W       = clk_div_pkg::CNT_W,
    parameter int                DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
    parameter logic [NUM_CH-1:0] INIT_LEVEL  = {NUM_CH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enabled,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [NUM_CH*CNT_W-1:0] div_value,
    input  logic [NUM_CH*CNT_W-1:0] phase_offset,
    output logic [NUM_CH-1:0]       out_clk,
    output logic [NUM_CH-1:0]       tick
);
    import clk_div_pkg::*;

    state_t                  state;
    state_t                  next_state;
    logic                    accept;
    logic                    run;
    logic                    sync;
    logic [NUM_CH*CNT_W-1:0] shadow_div;
    logic [NUM_CH*CNT_W-1:0] shadow_phase;

    assign accept = load_valid && load_ready;
    assign run    = (state == RUN) && enabled;
    assign sync   = (state == SYNC);

    always_comb begin
        next_state = sync ? (enabled ? RUN : IDLE) : accept ? SYNC : (enabled ? RUN : IDLE);
    end

    // load_ready is registered from next_state so it tracks the state and stays low in reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            load_ready   <= 1'b0;
            shadow_div   <= {NUM_CH{CNT_W'(DEFAULT_DIV)}};
            shadow_phase <= '0;
        end else begin
            state      <= next_state;
            load_ready <= (next_state != SYNC);
            if (accept) begin
                shadow_div   <= div_value;
                shadow_phase <= phase_offset;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV),
            .RST_PHASE  ((i * (DEFAULT_DIV + 1)) / NUM_CH),
            .INIT_LEVEL (INIT_LEVEL[i])
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .run         (run),
            .sync        (sync),
            .div_shadow  (shadow_div[i*CNT_W +: CNT_W]),
            .phase_shadow(shadow_phase[i*CNT_W +: CNT_W]),
            .out_clk     (out_clk[i]),
            .tick        (tick[i])
        );
    end
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: cycle model + scoreboard of {load_ready, tick, out_clk}, plus
// per-scenario tasks checking toggle timing, clamping, freezing, reset abort and back-to-back loads.
module tb_multi_clock_divider;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 9;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    enabled = 1'b0;
    logic                    load_valid = 1'b0;
    logic                    load_ready;
    logic [NUM_CH*CNT_W-1:0] div_value = '0;
    logic [NUM_CH*CNT_W-1:0] phase_offset = '0;
    logic [NUM_CH-1:0]       out_clk;
    logic [NUM_CH-1:0]       tick;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    multi_clock_divider dut (
        .clk         (clk),
        .reset       (reset),
        .enabled     (enabled),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .div_value   (div_value),
        .phase_offset(phase_offset),
        .out_clk     (out_clk),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_RUN, M_SYNC} mst_t;
    mst_t       m_st;
    logic       m_ready;
    logic       m_acc;
    int         m_div[NUM_CH], m_sdiv[NUM_CH], m_sph[NUM_CH], m_cnt[NUM_CH];
    logic [NUM_CH-1:0] m_out, m_tick;
    logic [2*NUM_CH:0] sb[$];

    // reference model: expected outputs after each edge are queued, compared on the next falling edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = M_IDLE;
            m_ready = 1'b0;
            m_out = '0;
            m_tick = '0;
            sb.delete();
            for (int c = 0; c < NUM_CH; c++) begin
                m_div[c] = 127;
                m_sdiv[c] = 127;
                m_sph[c] = 0;
                m_cnt[c] = (c * 128) / NUM_CH;
            end
        end else begin
            cycle++;
            m_acc = load_valid && m_ready;
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_st == M_SYNC) begin
                    m_div[c] = m_sdiv[c];
                    m_cnt[c] = (m_sph[c] > m_sdiv[c]) ? m_sdiv[c] : m_sph[c];
                    m_out[c] = 1'b0;
                    m_tick[c] = 1'b0;
                end else if (m_st == M_RUN && enabled) begin
                    if (m_cnt[c] == m_div[c]) begin
                        m_cnt[c] = 0;
                        m_out[c] = ~m_out[c];
                        m_tick[c] = 1'b1;
                    end else begin
                        m_cnt[c] = m_cnt[c] + 1;
                        m_tick[c] = 1'b0;
                    end
                end else begin
                    m_tick[c] = 1'b0;
                end
                if (m_acc) begin
                    m_sdiv[c] = int'(div_value[c*CNT_W +: CNT_W]);
                    m_sph[c] = int'(phase_offset[c*CNT_W +: CNT_W]);
                end
            end
            m_st = (m_st == M_SYNC) ? (enabled ? M_RUN : M_IDLE) : m_acc ? M_SYNC : (enabled ? M_RUN : M_IDLE);
            m_ready = (m_st != M_SYNC);
            sb.push_back({m_ready, m_tick, m_out});
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [2*NUM_CH:0] exp_v;
            exp_v = sb.pop_front();
            tests++;
            if ({load_ready, tick, out_clk} !== exp_v) begin
                fails++;
                $display("FAIL scoreboard cycle %0d: {ready,tick,out}=%b expected %b", cycle, {load_ready, tick, out_clk}, exp_v);
            end
        end
    end

    task automatic do_load(input int d0, input int d1, input int p0, input int p1);
        div_value = {CNT_W'(d1), CNT_W'(d0)};
        phase_offset = {CNT_W'(p1), CNT_W'(p0)};
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (out_clk !== 2'b00 || tick !== 2'b00 || load_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state out=%b tick=%b ready=%b expected 00/00/0", out_clk, tick, load_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (load_ready !== 1'b1 || out_clk !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle ready=%b out=%b expected 1/00", load_ready, out_clk);
        end
    endtask

    task automatic test_defaults();
        int t0[$], t1[$];
        logic [1:0] prev;
        prev = out_clk;
        enabled = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (out_clk[0] !== prev[0]) t0.push_back(n);
            if (out_clk[1] !== prev[1]) t1.push_back(n);
            prev = out_clk;
        end
        // one IDLE->RUN edge precedes the 128 (ch0) / 64 (ch1) counting edges
        tests++;
        if (t0.size() < 3 || t0[0] != 129) begin
            fails++;
            $display("FAIL default_first_ch0 got %0d expected 129", (t0.size() > 0) ? t0[0] : -1);
        end
        tests++;
        if (t1.size() < 3 || t1[0] != 65) begin
            fails++;
            $display("FAIL default_first_ch1 got %0d expected 65", (t1.size() > 0) ? t1[0] : -1);
        end
        tests++;
        if (t0.size() < 3 || t0[2] - t0[0] != 256 || t1.size() < 3 || t1[2] - t1[0] != 256) begin
            fails++;
            $display("FAIL default_period ch0 toggles=%0d ch1 toggles=%0d expected period 256", t0.size(), t1.size());
        end
    endtask

    task automatic test_load_fast();
        int ticks1, tog0;
        logic prev0;
        do_load(3, 0, 0, 0);
        tests++;
        if (load_ready !== 1'b0) begin
            fails++;
            $display("FAIL sync_ready got %b expected 0", load_ready);
        end
        @(negedge clk);
        tests++;
        if (out_clk !== 2'b00 || tick !== 2'b00 || load_ready !== 1'b1) begin
            fails++;
            $display("FAIL after_sync out=%b tick=%b ready=%b expected 00/00/1", out_clk, tick, load_ready);
        end
        ticks1 = 0;
        tog0 = 0;
        prev0 = out_clk[0];
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (tick[1] === 1'b1) ticks1++;
            if (out_clk[0] !== prev0) tog0++;
            prev0 = out_clk[0];
        end
        tests++;
        if (ticks1 != 16) begin
            fails++;
            $display("FAIL div0_tick got %0d expected 16", ticks1);
        end
        tests++;
        if (tog0 != 4) begin
            fails++;
            $display("FAIL div3_toggles got %0d expected 4", tog0);
        end
    endtask

    task automatic test_clamp();
        int t0[$], t1[$];
        do_load(10, 10, 500, 0);
        @(negedge clk);
        for (int n = 1; n <= 23; n++) begin
            @(negedge clk);
            if (tick[0] === 1'b1) t0.push_back(n);
            if (tick[1] === 1'b1) t1.push_back(n);
        end
        tests++;
        if (t0.size() != 3 || t0[0] != 1 || t0[1] != 12) begin
            fails++;
            $display("FAIL clamp_ch0 ticks=%0d first=%0d expected 3 ticks at 1,12,23", t0.size(), (t0.size() > 0) ? t0[0] : -1);
        end
        tests++;
        if (t1.size() != 2 || t1[0] != 11) begin
            fails++;
            $display("FAIL phase0_ch1 ticks=%0d first=%0d expected 2 ticks first at 11", t1.size(), (t1.size() > 0) ? t1[0] : -1);
        end
    endtask

    task automatic test_freeze();
        logic [1:0] snap;
        int bad, first;
        repeat (5) @(negedge clk);
        enabled = 1'b0;
        snap = out_clk;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tick !== 2'b00 || out_clk !== snap) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL freeze bad_cycles=%0d expected 0", bad);
        end
        enabled = 1'b1;
        first = -1;
        for (int n = 1; n <= 20 && first < 0; n++) begin
            @(negedge clk);
            if (tick[0] === 1'b1) first = n;
        end
        // ch0 counter was at 5 of 10: one IDLE->RUN edge then 6 counting edges
        tests++;
        if (first != 7) begin
            fails++;
            $display("FAIL resume_ch0 first tick at %0d expected 7", first);
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        logic prev0;
        do_load(5, 5, 2, 2);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (out_clk !== 2'b00 || tick !== 2'b00 || load_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_sync out=%b tick=%b ready=%b expected 00/00/0", out_clk, tick, load_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        f0 = -1;
        prev0 = out_clk[0];
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            if (out_clk[0] !== prev0 && f0 < 0) f0 = n;
            prev0 = out_clk[0];
        end
        tests++;
        if (f0 != 129) begin
            fails++;
            $display("FAIL defaults_restored first ch0 toggle %0d expected 129", f0);
        end
        tests++;
        if (out_clk !== 2'b11) begin
            fails++;
            $display("FAIL pre_reset_level out=%b expected 11", out_clk);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (out_clk !== 2'b00 || tick !== 2'b00) begin
            fails++;
            $display("FAIL reset_mid_period out=%b tick=%b expected 00/00", out_clk, tick);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [5:0] mask;
        int first;
        mask = '0;
        load_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            div_value = {CNT_W'(k + 1), CNT_W'(k + 1)};
            phase_offset = '0;
            mask[k] = load_ready;
            @(negedge clk);
        end
        load_valid = 1'b0;
        tests++;
        if (mask !== 6'b010101) begin
            fails++;
            $display("FAIL b2b_accept_pattern got %b expected 010101", mask);
        end
        first = -1;
        for (int n = 1; n <= 20 && first < 0; n++) begin
            @(negedge clk);
            if (tick[0] === 1'b1) first = n;
        end
        // last accepted div is 5 with phase 0 -> six counting edges to the first toggle
        tests++;
        if (first != 6) begin
            fails++;
            $display("FAIL b2b_last_wins first tick at %0d expected 6", first);
        end
        repeat (14) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_load_fast();
        test_clamp();
        test_freeze();
        test_reset_mid();
        test_back_to_back();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
